// File: rtl/i2c_slave_regs.sv
// I2C target with a small byte-wide register file: pointer-addressed writes, auto-increment reads.
// SCL/SDA are oversampled on clock; SDA is only ever pulled low or released.
module i2c_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42,
    parameter int         NUM_REGS   = 4,
    parameter int         PTR_W      = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  scl,
    inout  wire                   sda,
    output logic [8*NUM_REGS-1:0] reg_flat,
    output logic                  wr_strobe,
    output logic [PTR_W-1:0]      wr_addr,
    output logic [7:0]            wr_data,
    output logic                  busy
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        IGNORE,
        WR_PTR,
        PTR_ACK,
        WR_DATA,
        DATA_ACK,
        RD_DATA,
        RD_ACK
    } state_t;

    state_t             state;
    logic [2:0]         scl_sync;
    logic [2:0]         sda_sync;
    logic               sda_oe;
    logic               rw;
    logic               rd_ack_ok;
    logic [7:0]         shift_reg;
    logic [3:0]         bit_cnt;
    logic [PTR_W-1:0]   ptr;
    logic [7:0]         regs [NUM_REGS];

    logic               scl_s;
    logic               scl_d;
    logic               sda_s;
    logic               sda_d;
    logic               scl_rise;
    logic               scl_fall;
    logic               start_det;
    logic               stop_det;
    logic [7:0]         rx_byte;
    logic [PTR_W-1:0]   ptr_next;

    assign sda = sda_oe ? 1'b0 : 1'bz;

    // Synchronizers reset to the idle-high bus level so no false edge appears on reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync <= 3'b111;
            sda_sync <= 3'b111;
        end else begin
            scl_sync <= {scl_sync[1:0], scl};
            sda_sync <= {sda_sync[1:0], sda};
        end
    end

    assign scl_s     = scl_sync[1];
    assign scl_d     = scl_sync[2];
    assign sda_s     = sda_sync[1];
    assign sda_d     = sda_sync[2];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & ~sda_s & sda_d & ~sda_oe;
    assign stop_det  = scl_s & scl_d & sda_s & ~sda_d & ~sda_oe;
    assign rx_byte   = {shift_reg[6:0], sda_s};
    assign ptr_next  = ptr + PTR_W'(1);

    always_comb begin
        reg_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_flat[8*i +: 8] = regs[i];
        end
    end

    // In the ACK states sda_oe doubles as the phase flag: first fall starts the ACK, second ends it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sda_oe    <= 1'b0;
            rw        <= 1'b0;
            rd_ack_ok <= 1'b0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            ptr       <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_strobe <= 1'b0;
            if (stop_det) begin
                state     <= IDLE;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                bit_cnt   <= '0;
                rd_ack_ok <= 1'b0;
            end else if (start_det) begin
                state     <= ADDR;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                bit_cnt   <= '0;
                rd_ack_ok <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shift_reg <= rx_byte;
                            bit_cnt   <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= '0;
                                if (rx_byte[7:1] == SLAVE_ADDR) begin
                                    rw    <= rx_byte[0];
                                    busy  <= 1'b1;
                                    state <= ADDR_ACK;
                                end else begin
                                    state <= IGNORE;
                                end
                            end
                        end
                    end
                    WR_PTR: begin
                        if (scl_rise) begin
                            shift_reg <= rx_byte;
                            bit_cnt   <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= '0;
                                ptr     <= rx_byte[PTR_W-1:0];
                                state   <= PTR_ACK;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (scl_rise) begin
                            shift_reg <= rx_byte;
                            bit_cnt   <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt   <= '0;
                                regs[ptr] <= rx_byte;
                                wr_strobe <= 1'b1;
                                wr_addr   <= ptr;
                                wr_data   <= rx_byte;
                                ptr       <= ptr_next;
                                state     <= DATA_ACK;
                            end
                        end
                    end
                    ADDR_ACK, PTR_ACK, DATA_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                if (state == ADDR_ACK && rw) begin
                                    shift_reg <= regs[ptr];
                                    sda_oe    <= ~regs[ptr][7];
                                    bit_cnt   <= 4'd1;
                                    state     <= RD_DATA;
                                end else if (state == ADDR_ACK) begin
                                    state <= WR_PTR;
                                end else begin
                                    state <= WR_DATA;
                                end
                            end
                        end
                    end
                    RD_DATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= RD_ACK;
                            end else begin
                                shift_reg <= {shift_reg[6:0], 1'b0};
                                sda_oe    <= ~shift_reg[6];
                                bit_cnt   <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            ptr <= ptr_next;
                            if (!sda_s) begin
                                shift_reg <= regs[ptr_next];
                                rd_ack_ok <= 1'b1;
                            end else begin
                                state <= IGNORE;
                            end
                        end else if (scl_fall && rd_ack_ok) begin
                            rd_ack_ok <= 1'b0;
                            sda_oe    <= ~shift_reg[7];
                            bit_cnt   <= 4'd1;
                            state     <= RD_DATA;
                        end
                    end
                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: bus-level master tasks plus a write-strobe scoreboard.
`timescale 1ns/1ps
module tb_i2c_slave_regs;

    localparam int QTR  = 40;
    localparam int HALF = 80;

    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
    } wr_exp_t;

    logic        clock;
    logic        reset_n;
    logic        scl;
    logic        master_low;
    wire         sda_bus;
    logic [31:0] reg_flat;
    logic        wr_strobe;
    logic [1:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy;

    int          checks;
    int          errors;
    wr_exp_t     exp_q[$];

    assign sda_bus = master_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_slave_regs #(
        .SLAVE_ADDR(7'h42),
        .NUM_REGS  (4),
        .PTR_W     (2)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .scl      (scl),
        .sda      (sda_bus),
        .reg_flat (reg_flat),
        .wr_strobe(wr_strobe),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic bus_bit(input logic b, output logic s);
        #QTR master_low = ~b;
        #QTR scl = 1'b1;
        #QTR s = sda_bus;
        #QTR scl = 1'b0;
    endtask

    task automatic bus_start();
        master_low = 1'b1;
        #HALF scl = 1'b0;
    endtask

    task automatic bus_restart();
        #QTR master_low = 1'b0;
        #QTR scl = 1'b1;
        #HALF master_low = 1'b1;
        #HALF scl = 1'b0;
    endtask

    task automatic bus_stop();
        #QTR master_low = 1'b1;
        #QTR scl = 1'b1;
        #HALF master_low = 1'b0;
        #HALF;
    endtask

    // Master writes one byte and checks the ACK bit the target returns.
    task automatic applyStimulus(input logic [7:0] data, input logic exp_ack, input string name);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(data[i], s);
        end
        bus_bit(1'b1, s);
        checkOutput(name, {31'd0, s}, {31'd0, exp_ack});
    endtask

    task automatic read_byte(input logic [7:0] expected, input logic master_ack, input string name);
        logic [7:0] got;
        logic       s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            got[i] = s;
        end
        bus_bit(master_ack, s);
        checkOutput(name, {24'd0, got}, {24'd0, expected});
    endtask

    task automatic expect_write(input logic [1:0] addr, input logic [7:0] data);
        wr_exp_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every write strobe is matched against the oldest expected write.
    always @(negedge clock) begin
        if (reset_n && wr_strobe) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                wr_exp_t e;
                e = exp_q.pop_front();
                checkOutput("wr_addr", {30'd0, wr_addr}, {30'd0, e.addr});
                checkOutput("wr_data", {24'd0, wr_data}, {24'd0, e.data});
                checkOutput("reg_flat_at_strobe", {24'd0, reg_flat[8*int'(wr_addr) +: 8]}, {24'd0, e.data});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b0;
        scl        = 1'b1;
        master_low = 1'b0;
        #25 reset_n = 1'b1;
        #100;

        checkOutput("reset_regs", reg_flat, 32'h0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_strobe", {31'd0, wr_strobe}, 32'd0);
        checkOutput("reset_sda", {31'd0, sda_bus}, 32'd1);

        $display("[TB] write 0xA5,0x3C at pointer 1");
        bus_start();
        applyStimulus(8'h84, 1'b0, "wr_addr_ack");
        checkOutput("busy_after_match", {31'd0, busy}, 32'd1);
        applyStimulus(8'h01, 1'b0, "wr_ptr_ack");
        expect_write(2'd1, 8'hA5);
        applyStimulus(8'hA5, 1'b0, "wr_data0_ack");
        expect_write(2'd2, 8'h3C);
        applyStimulus(8'h3C, 1'b0, "wr_data1_ack");
        bus_stop();
        checkOutput("busy_after_stop", {31'd0, busy}, 32'd0);
        checkOutput("regs_after_write", reg_flat, 32'h003CA500);

        $display("[TB] read back with repeated START");
        bus_start();
        applyStimulus(8'h84, 1'b0, "rd_addr_w_ack");
        applyStimulus(8'h01, 1'b0, "rd_ptr_ack");
        bus_restart();
        applyStimulus(8'h85, 1'b0, "rd_addr_r_ack");
        read_byte(8'hA5, 1'b0, "rd_byte0");
        read_byte(8'h3C, 1'b1, "rd_byte1");
        #QTR;
        checkOutput("sda_released_after_nack", {31'd0, sda_bus}, 32'd1);
        checkOutput("busy_before_stop", {31'd0, busy}, 32'd1);
        bus_stop();
        checkOutput("busy_after_read_stop", {31'd0, busy}, 32'd0);

        $display("[TB] address mismatch");
        bus_start();
        applyStimulus(8'h86, 1'b1, "mismatch_nack");
        checkOutput("mismatch_busy", {31'd0, busy}, 32'd0);
        bus_stop();
        checkOutput("mismatch_regs", reg_flat, 32'h003CA500);

        $display("[TB] pointer wrap");
        bus_start();
        applyStimulus(8'h84, 1'b0, "wrap_addr_ack");
        applyStimulus(8'h03, 1'b0, "wrap_ptr_ack");
        expect_write(2'd3, 8'h11);
        applyStimulus(8'h11, 1'b0, "wrap_data0_ack");
        expect_write(2'd0, 8'h22);
        applyStimulus(8'h22, 1'b0, "wrap_data1_ack");
        bus_stop();
        checkOutput("regs_after_wrap", reg_flat, 32'h113CA522);

        $display("[TB] abort mid-byte");
        begin
            logic s;
            bus_start();
            applyStimulus(8'h84, 1'b0, "abort_addr_ack");
            applyStimulus(8'h00, 1'b0, "abort_ptr_ack");
            bus_bit(1'b1, s);
            bus_bit(1'b0, s);
            bus_bit(1'b1, s);
            bus_bit(1'b0, s);
            bus_stop();
        end
        checkOutput("abort_regs", reg_flat, 32'h113CA522);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_sda", {31'd0, sda_bus}, 32'd1);

        $display("[TB] reset while target drives a 0 bit");
        bus_start();
        applyStimulus(8'h84, 1'b0, "rst_addr_w_ack");
        applyStimulus(8'h00, 1'b0, "rst_ptr_ack");
        bus_restart();
        applyStimulus(8'h85, 1'b0, "rst_addr_r_ack");
        #60;
        checkOutput("target_drives_msb0", {31'd0, sda_bus}, 32'd0);
        reset_n = 1'b0;
        #1;
        checkOutput("sda_released_in_reset", {31'd0, sda_bus}, 32'd1);
        checkOutput("regs_cleared_in_reset", reg_flat, 32'h0);
        checkOutput("busy_cleared_in_reset", {31'd0, busy}, 32'd0);
        #50;
        scl        = 1'b1;
        master_low = 1'b0;
        #50 reset_n = 1'b1;
        #200;

        checkOutput("pending_strobes", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_slave_regs.md
Name: i2c_slave_regs

Overview:
- I2C target device answering the team's I2C master on the shared SDA/SCL bus; sits directly downstream of the master, consuming its START/address/mode/data/STOP sequences.
- Exposes a small byte-wide register file: pointer-addressed writes, auto-increment reads.
- Oversamples SCL/SDA with its own faster clock; no clock stretching. Drives SDA open-drain only.

Parameters:
- SLAVE_ADDR, 7'h42, 7-bit bus address this device answers to.
- NUM_REGS, 4, number of 8-bit registers; power of two, 2..16.
- PTR_W, 2, pointer width = log2(NUM_REGS).

Ports:
- clock  input  1  sampling clock; must be >= 8x SCL frequency.
- reset_n  input  1  asynchronous, active-low reset.
- scl  input  1  I2C clock from bus; never driven.
- sda  inout  1  I2C data; pulled low when driving 0, otherwise high-Z.
- reg_flat  output  8*NUM_REGS  register file contents; reg i is bits [8i+7:8i].
- wr_strobe  output  1  one-clock pulse when a data byte is committed.
- wr_addr  output  PTR_W  register index of the committed byte.
- wr_data  output  8  committed byte.
- busy  output  1  high from address match until STOP or next START.

Behaviour:
- Reset (async, reset_n=0): state IDLE, SDA released, all registers 8'h00, pointer 0, shift reg 0, bit counter 0, wr_strobe 0, wr_addr 0, wr_data 0, busy 0. Reset mid-transfer releases SDA immediately.
- Input sync: scl and sda each pass through 2-flop synchronizers, plus a third flop for edge detect. All decisions use synchronized values; edges are acted on 3 clocks after the pin edge.
- START: synced SDA falls while synced SCL high. Valid from any state, so repeated START works. Action: enter ADDR, clear bit counter, busy=0.
- STOP: synced SDA rises while synced SCL high. From any state: release SDA, enter IDLE, busy=0.
- START/STOP detection is inhibited while the block itself drives SDA.
- Data is sampled on SCL rising edges and shifted MSB first. The block changes its SDA drive only on SCL falling edges.
- States:
  - IDLE: SDA released; waits for START.
  - ADDR: shift 8 bits (7 address + R/W). On the 8th rising edge:
    - address==SLAVE_ADDR: set rw, busy=1; go to ADDR_ACK.
    - mismatch: go to IGNORE.
  - ADDR_ACK: drive SDA=0 from the next SCL fall to the following SCL fall. Then:
    - rw=0: go to WR_PTR.
    - rw=1: load the register at pointer into the shift register, drive its MSB, go to RD_DATA.
  - IGNORE: SDA released; waits for START or STOP.
  - WR_PTR: shift 8 bits; pointer <= byte[PTR_W-1:0] (upper bits ignored); then PTR_ACK (ACK as in ADDR_ACK), then WR_DATA.
  - WR_DATA: shift 8 bits. On the 8th rising edge:
    - reg[pointer] <= byte; wr_strobe pulses 1 clock with wr_addr=pointer, wr_data=byte.
    - pointer <= pointer+1, wrapping modulo NUM_REGS.
    - go to DATA_ACK (ACK as above), then WR_DATA again.
  - RD_DATA: drive bits MSB first, each on an SCL fall. After the 8th bit's SCL fall, release SDA and go to RD_ACK.
  - RD_ACK: sample SDA on SCL rising edge; pointer increments (with wrap).
    - sampled 0 (ACK): load the next register and continue RD_DATA.
    - sampled 1 (NACK): go to IGNORE until STOP/START.
- Writes are always ACKed; there is no NACK on data.
- A STOP or START in the middle of a byte discards the partial byte; no wr_strobe is issued.
- reg_flat updates one clock after the committing SCL rise; wr_strobe is asserted in the same cycle.

Test Plan:
- Write: START, 0x84 (addr 0x42, W), 0x01, 0xA5, 0x3C, STOP -> ACK on all 4 bytes; reg1=0xA5, reg2=0x3C; two wr_strobe pulses (addr 1/0xA5, addr 2/0x3C).
- Read with repeated START: after the write above, START, 0x84, 0x01, repeated START, 0x85, master ACK, master NACK, STOP -> bytes 0xA5, 0x3C returned MSB first; SDA released after NACK; busy=0 after STOP.
- Address mismatch: START, 0x86 (addr 0x43) -> SDA stays high at the ACK bit; no register change; busy stays 0.
- Pointer wrap: write ptr 0x03, data 0x11, 0x22 -> reg3=0x11, reg0=0x22; second wr_addr=0.
- Abort: STOP after 4 bits of a data byte -> no wr_strobe; registers unchanged; state IDLE.
- Reset mid-read: assert reset_n=0 while driving a 0 bit -> SDA released within the reset assertion; all registers read 0x00.
